// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared 8-bit system bus.
// One-cycle turnaround between owners; unlocked owners can be preempted after MAX_HOLD cycles.
module bus_arbiter #(
    parameter int  LANES    = 3,
    parameter int  MAX_HOLD = 8,
    localparam int OWNER_W  = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               freeze,
    input  logic [LANES-1:0]   req,
    input  logic [LANES-1:0]   lock,
    output logic [LANES-1:0]   grant,
    output logic [OWNER_W-1:0] owner,
    output logic               busy,
    output logic               preempt,
    output logic [7:0]         hold_count
);

    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_TURN} state_t;

    state_t             r_state;
    logic [LANES-1:0]   r_grant;
    logic [OWNER_W-1:0] r_owner;
    logic               r_busy;
    logic               r_preempt;
    logic [7:0]         r_hold;
    logic [OWNER_W-1:0] r_last;

    state_t             w_nxt_state;
    logic [LANES-1:0]   w_nxt_grant;
    logic [OWNER_W-1:0] w_nxt_owner;
    logic               w_nxt_busy;
    logic               w_nxt_preempt;
    logic [7:0]         w_nxt_hold;
    logic [OWNER_W-1:0] w_nxt_last;

    logic               w_pick_vld;
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_own_req;
    logic               w_own_lock;
    logic               w_others;
    logic               w_hold_lim;

    // Scan last+1, last+2, ... wrapping at LANES; first requester wins.
    always_comb begin : pick
        logic [OWNER_W:0] cand;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        cand       = '0;
        for (int k = 1; k <= LANES; k++) begin
            cand = {1'b0, r_last} + (OWNER_W+1)'(k);
            if (cand >= (OWNER_W+1)'(LANES))
                cand = cand - (OWNER_W+1)'(LANES);
            if (!w_pick_vld && req[cand[OWNER_W-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = cand[OWNER_W-1:0];
            end
        end
    end

    // The registered grant is the owner mask, so it selects the owner's req/lock bits.
    assign w_own_req  = |(req & r_grant);
    assign w_own_lock = |(lock & r_grant);
    assign w_others   = |(req & ~r_grant);
    assign w_hold_lim = (r_hold >= 8'(MAX_HOLD - 1));

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_grant   = r_grant;
        w_nxt_owner   = r_owner;
        w_nxt_busy    = r_busy;
        w_nxt_preempt = 1'b0;
        w_nxt_hold    = r_hold;
        w_nxt_last    = r_last;
        case (r_state)
            S_OWNED: begin
                w_nxt_hold = (r_hold == 8'hFF) ? r_hold : r_hold + 8'd1;
                if (!w_own_req || (!w_own_lock && w_hold_lim && w_others)) begin
                    // Release takes priority: preempt only fires while the owner still requests.
                    w_nxt_preempt = w_own_req;
                    w_nxt_state   = S_TURN;
                    w_nxt_grant   = '0;
                    w_nxt_owner   = '0;
                    w_nxt_busy    = 1'b0;
                    w_nxt_hold    = '0;
                    w_nxt_last    = r_owner;
                end
            end
            default: begin
                w_nxt_hold = '0;
                if (w_pick_vld) begin
                    w_nxt_state             = S_OWNED;
                    w_nxt_grant             = '0;
                    w_nxt_grant[w_pick_idx] = 1'b1;
                    w_nxt_owner             = w_pick_idx;
                    w_nxt_busy              = 1'b1;
                end else begin
                    w_nxt_state = S_IDLE;
                    w_nxt_grant = '0;
                    w_nxt_owner = '0;
                    w_nxt_busy  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_hold    <= '0;
            r_last    <= OWNER_W'(LANES - 1);
        end else if (freeze) begin
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_grant   <= w_nxt_grant;
            r_owner   <= w_nxt_owner;
            r_busy    <= w_nxt_busy;
            r_preempt <= w_nxt_preempt;
            r_hold    <= w_nxt_hold;
            r_last    <= w_nxt_last;
        end
    end

    assign grant      = r_grant;
    assign owner      = r_owner;
    assign busy       = r_busy;
    assign preempt    = r_preempt;
    assign hold_count = r_hold;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them and checks the grant invariants.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       freeze = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] lock = 3'b000;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;
    logic [7:0] hold_count;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit done = 1'b0;
    logic [2:0] prev_g = 3'b000;

    // Snapshot of outputs taken between clock edges (async reset check).
    logic [2:0] snap_g;
    logic [1:0] snap_o;
    logic       snap_b, snap_p;
    logic [7:0] snap_h;

    typedef struct {
        int         cyc;
        string      nm;
        logic [2:0] g;
        logic [1:0] o;
        logic       b;
        logic       p;
        int         h;
        bit         snap;
    } exp_t;
    exp_t q[$];

    bus_arbiter #(.LANES(3), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .req(req), .lock(lock),
        .grant(grant), .owner(owner), .busy(busy), .preempt(preempt),
        .hold_count(hold_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int c, input string nm, input logic [2:0] g,
                          input logic [1:0] o, input logic b, input logic p,
                          input int h, input bit snap = 1'b0);
        exp_t e;
        e.cyc = c; e.nm = nm; e.g = g; e.o = o; e.b = b; e.p = p; e.h = h; e.snap = snap;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [2:0] ag;
        logic [1:0] ao;
        logic       ab, ap;
        logic [7:0] ah;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: check skipped, now cyc %0d, required at cyc %0d", e.nm, cyc, e.cyc);
            end else begin
                if (e.snap) begin
                    ag = snap_g; ao = snap_o; ab = snap_b; ap = snap_p; ah = snap_h;
                end else begin
                    ag = grant; ao = owner; ab = busy; ap = preempt; ah = hold_count;
                end
                if (ag !== e.g || ao !== e.o || ab !== e.b || ap !== e.p ||
                    (e.h >= 0 && ah !== 8'(e.h))) begin
                    bad++;
                    $display("FAIL %s cyc=%0d: got g=%b o=%0d b=%b p=%b h=%0d, want g=%b o=%0d b=%b p=%b h=%0d",
                             e.nm, cyc, ag, ao, ab, ap, ah, e.g, e.o, e.b, e.p, e.h);
                end
            end
        end
        total++;
        if (!$onehot0(grant) ||
            (busy ? (grant != (3'(1) << owner)) : (owner != 2'd0 || grant != 3'b000)) ||
            (prev_g != 3'b000 && grant != 3'b000 && grant != prev_g)) begin
            bad++;
            $display("FAIL invariant cyc=%0d: got grant=%b prev=%b owner=%0d busy=%b, want one-hot owner grant with a gap",
                     cyc, grant, prev_g, owner, busy);
        end
        prev_g <= grant;
        if (done) begin
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d pending checks, want 0", q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, want finish before 400000");
        $fatal(1);
    end

    initial begin : stim
        int c, p0, s, l, e, f, r;
        // Reset with all lanes requesting
        req = 3'b111;
        @(negedge clk);
        c = cyc;
        exp_at(c + 1, "rst_a", 3'b000, 2'd0, 1'b0, 1'b0, 0);
        exp_at(c + 2, "rst_b", 3'b000, 2'd0, 1'b0, 1'b0, 0);
        wait_cyc(c + 2);
        rst_n = 1'b1;
        p0 = cyc + 1;
        // Round robin, each owner holds 8 cycles then gets preempted
        exp_at(p0,      "rr_first",  3'b001, 2'd0, 1'b1, 1'b0, 0);
        exp_at(p0 + 1,  "rr_h1",     3'b001, 2'd0, 1'b1, 1'b0, 1);
        exp_at(p0 + 7,  "rr_h7",     3'b001, 2'd0, 1'b1, 1'b0, 7);
        exp_at(p0 + 8,  "rr_pre0",   3'b000, 2'd0, 1'b0, 1'b1, -1);
        exp_at(p0 + 9,  "rr_l1",     3'b010, 2'd1, 1'b1, 1'b0, 0);
        exp_at(p0 + 16, "rr_l1h7",   3'b010, 2'd1, 1'b1, 1'b0, 7);
        exp_at(p0 + 17, "rr_pre1",   3'b000, 2'd0, 1'b0, 1'b1, -1);
        exp_at(p0 + 18, "rr_l2",     3'b100, 2'd2, 1'b1, 1'b0, 0);
        exp_at(p0 + 26, "rr_pre2",   3'b000, 2'd0, 1'b0, 1'b1, -1);
        exp_at(p0 + 27, "rr_wrap",   3'b001, 2'd0, 1'b1, 1'b0, 0);
        exp_at(p0 + 28, "rr_rel",    3'b000, 2'd0, 1'b0, 1'b0, -1);
        exp_at(p0 + 29, "rr_idle",   3'b000, 2'd0, 1'b0, 1'b0, 0);
        wait_cyc(p0 + 27);
        req = 3'b000;
        // Voluntary release by lane 1
        wait_cyc(p0 + 29);
        s = cyc;
        req = 3'b010;
        exp_at(s + 1, "vr_g",   3'b010, 2'd1, 1'b1, 1'b0, 0);
        exp_at(s + 2, "vr_h1",  3'b010, 2'd1, 1'b1, 1'b0, 1);
        exp_at(s + 3, "vr_h2",  3'b010, 2'd1, 1'b1, 1'b0, 2);
        exp_at(s + 4, "vr_rel", 3'b000, 2'd0, 1'b0, 1'b0, -1);
        exp_at(s + 5, "vr_idl", 3'b000, 2'd0, 1'b0, 1'b0, 0);
        wait_cyc(s + 3);
        req = 3'b000;
        // Locked owner is never preempted
        wait_cyc(s + 5);
        l = cyc;
        req = 3'b010;
        lock = 3'b010;
        exp_at(l + 1,  "lk_g",    3'b010, 2'd1, 1'b1, 1'b0, 0);
        exp_at(l + 20, "lk_h19",  3'b010, 2'd1, 1'b1, 1'b0, 19);
        exp_at(l + 40, "lk_h39",  3'b010, 2'd1, 1'b1, 1'b0, 39);
        exp_at(l + 41, "lk_pre",  3'b000, 2'd0, 1'b0, 1'b1, -1);
        exp_at(l + 42, "lk_next", 3'b001, 2'd0, 1'b1, 1'b0, 0);
        wait_cyc(l + 1);
        req = 3'b011;
        wait_cyc(l + 40);
        lock = 3'b000;
        // Hold counter saturation under lock
        wait_cyc(l + 42);
        lock = 3'b001;
        e = l + 42 + 260;
        exp_at(l + 42 + 100, "sat_h100", 3'b001, 2'd0, 1'b1, 1'b0, 100);
        exp_at(l + 42 + 255, "sat_h255", 3'b001, 2'd0, 1'b1, 1'b0, 255);
        exp_at(l + 42 + 257, "sat_hold", 3'b001, 2'd0, 1'b1, 1'b0, 255);
        exp_at(e + 1, "sat_rel", 3'b000, 2'd0, 1'b0, 1'b0, -1);
        exp_at(e + 2, "sat_idl", 3'b000, 2'd0, 1'b0, 1'b0, 0);
        wait_cyc(e);
        req = 3'b000;
        lock = 3'b000;
        // Freeze for 5 cycles delays the preemption by 5
        wait_cyc(e + 2);
        f = cyc;
        req = 3'b111;
        exp_at(f + 5, "fz_h4", 3'b010, 2'd1, 1'b1, 1'b0, 4);
        for (int i = 6; i <= 10; i++)
            exp_at(f + i, "fz_held", 3'b010, 2'd1, 1'b1, 1'b0, 4);
        exp_at(f + 11, "fz_h5",   3'b010, 2'd1, 1'b1, 1'b0, 5);
        exp_at(f + 13, "fz_h7",   3'b010, 2'd1, 1'b1, 1'b0, 7);
        exp_at(f + 14, "fz_pre",  3'b000, 2'd0, 1'b0, 1'b1, -1);
        exp_at(f + 15, "fz_l2",   3'b100, 2'd2, 1'b1, 1'b0, 0);
        exp_at(f + 16, "fz_rel",  3'b000, 2'd0, 1'b0, 1'b0, -1);
        wait_cyc(f + 5);
        freeze = 1'b1;
        wait_cyc(f + 10);
        freeze = 1'b0;
        wait_cyc(f + 15);
        req = 3'b000;
        // Async reset while lane 2 owns
        wait_cyc(f + 17);
        r = cyc;
        req = 3'b100;
        exp_at(r + 1, "ar_g2",   3'b100, 2'd2, 1'b1, 1'b0, 0);
        exp_at(r + 3, "ar_drop", 3'b000, 2'd0, 1'b0, 1'b0, 0, 1'b1);
        exp_at(r + 4, "ar_l0",   3'b001, 2'd0, 1'b1, 1'b0, 0);
        exp_at(r + 5, "ar_l0h1", 3'b001, 2'd0, 1'b1, 1'b0, 1);
        wait_cyc(r + 2);
        req = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        snap_g = grant; snap_o = owner; snap_b = busy; snap_p = preempt; snap_h = hold_count;
        wait_cyc(r + 3);
        rst_n = 1'b1;
        wait_cyc(r + 6);
        done = 1'b1;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the 8-bit system bus between several bus masters: the control unit, the bootloader, and a future debug/UART loader. Each master requests with a level signal. The block grants one lane at a time, round-robin, with a mandatory one-cycle turnaround so no two drivers overlap. A hold limit lets a waiting master preempt an unlocked owner. The one-hot grant output feeds the bus module's lane_select for master lanes.

Parameters:
LANES, 3, number of requesting masters (2..8)
MAX_HOLD, 8, cycles an unlocked owner may keep the bus while others wait (2..255)
OWNER_W, $clog2(LANES), width of owner index (derived, not overridden)

Ports:
clk  input  1  CPU clock (cpu_clk domain)
rst_n  input  1  asynchronous active-low reset
freeze  input  1  1 = hold all state (clock-halt/debug stop)
req  input  LANES  per-lane bus request, level; held until done
lock  input  LANES  per-lane lock; owner with lock=1 is never preempted
grant  output  LANES  one-hot grant, registered; drives lane_select
owner  output  OWNER_W  index of granted lane; 0 when not busy
busy  output  1  1 when any grant asserted
preempt  output  1  one-cycle pulse when the owner is forcibly released
hold_count  output  8  cycles current owner has held the bus, saturating at 255

Behaviour:
- Reset (async on rst_n low, released synchronously to clk): state=IDLE, grant=0, owner=0, busy=0, preempt=0, hold_count=0, last=LANES-1, so lane 0 wins the first arbitration.
- All outputs are registered. No combinational path from req/lock to grant.
- States: IDLE, OWNED, TURN.
- Arbitration (IDLE or TURN): if any req, pick the first requesting lane scanning last+1, last+2, … modulo LANES. Next edge: grant that lane, owner=index, busy=1, hold_count=0, state=OWNED. Latency from req rising to grant: 1 cycle. If no req: grant=0, state=IDLE.
- OWNED, each cycle:
  - hold_count increments, saturating at 255.
  - If req[owner]=0: next edge grant=0, busy=0, owner=0, last=owner, state=TURN.
  - Else if lock[owner]=0, hold_count ≥ MAX_HOLD-1, and any other req is set: next edge grant=0, preempt=1 for exactly that cycle, last=owner, state=TURN.
  - Otherwise grant is held.
- TURN: grant=0 for exactly one cycle. Arbitration runs in TURN, so the gap between owners is exactly 1 cycle. A preempted master keeping req high re-enters round-robin at lowest priority.
- lock is sampled only in OWNED. A lock on a non-owner has no effect. Lock held indefinitely means the owner is never preempted, which is legal.
- Simultaneous release and preempt condition: release wins and preempt stays 0.
- freeze=1 overrides everything except reset. State, grant, owner, hold_count and last are held; preempt is forced 0. Requests arriving during freeze are arbitrated on the first unfrozen edge.
- Grant invariant: at most one grant bit is ever set. Grant is never set in the cycle after a grant bit clears.
- Reset mid-ownership: grant drops immediately (asynchronously). The next arbitration starts from lane 0.
- Request bits for lanes ≥ LANES do not exist. owner is always < LANES.

Test Plan:
- Reset/idle: hold rst_n low with req=3'b111 → grant=0, busy=0. Release reset → grant=3'b001 one cycle later, owner=0, hold_count=0.
- Round robin: req=3'b111 constant, lock=0, MAX_HOLD=8 → grants 001,000,010,000,100,000,001… Each owner holds 8 cycles, and preempt pulses once per handoff.
- Voluntary release: req=3'b010 for 3 cycles, then 0 → grant=010 for 3 cycles, then 000, busy=0, preempt never 1, hold_count reached 2.
- Lock: lane 1 owns with lock=3'b010 and req=3'b011 for 40 cycles → grant stays 010, hold_count=39, preempt=0. Drop lock → preempt next cycle, then grant=001 after a 1-cycle gap.
- Freeze: mid-ownership with hold_count=4, assert freeze 5 cycles → all outputs constant. Deassert → hold_count resumes at 5. Preempt is delayed by exactly 5 cycles.
- Async reset mid-operation: assert rst_n low between clock edges while grant=100 → grant=0 before the next edge. After release, lane 0 gets priority.
